// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// Optional macro SIGNED_OVF_EN adds the signed-overflow flag ovf.
interface multiword_add_seq_if #(
    parameter int BW    = 16,
    parameter int WORDS = 4
);
    localparam int W = BW * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SIGNED_OVF_EN
    logic         ovf;
`endif

    // Producer/consumer side of the adder
    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SIGNED_OVF_EN
        , input ovf
`endif
    );

    // Adder side
    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SIGNED_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Chunk-serial wide adder: one BW-bit Kogge-Stone prefix adder is reused
// WORDS times, LSB chunk first, with the carry chained through a register.
// Optional macro SIGNED_OVF_EN adds the signed-overflow output ovf.

// Combinational BW-bit Kogge-Stone adder with carry-in.
module kogge_stone_4bit #(
    parameter int bw = 16
) (
    input  logic [bw-1:0] a,
    input  logic [bw-1:0] b,
    input  logic          cin,
    output logic [bw-1:0] s,
    output logic          cout
);
    localparam int LV = $clog2(bw);

    logic [bw-1:0] g, p, g_n, p_n;
    logic [bw:0]   c;

    // Prefix doubling of generate/propagate, then fold in carry-in
    always_comb begin
        g   = a & b;
        p   = a ^ b;
        g_n = '0;
        p_n = '0;
        for (int l = 0; l < LV; l++) begin
            g_n = g;
            p_n = p;
            for (int i = (1 << l); i < bw; i++) begin
                g_n[i] = g[i] | (p[i] & g[i-(1<<l)]);
                p_n[i] = p[i] & p[i-(1<<l)];
            end
            g = g_n;
            p = p_n;
        end
        c    = {g | (p & {bw{cin}}), cin};
        s    = (a ^ b) ^ c[bw-1:0];
        cout = c[bw];
    end
endmodule

module multiword_add_seq #(
    parameter int BW    = 16,
    parameter int WORDS = 4
) (
    input  logic clk,
    input  logic rst,
    multiword_add_seq_if.slave bus
);
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_nx;
    logic [KW-1:0]            k;
    logic [WORDS-1:0][BW-1:0] a_q, b_q, sum_q;
    logic                     carry, cout_q;
    logic [BW-1:0]            add_s;
    logic                     add_co;
    logic                     last;
    logic                     in_ready, out_valid;

    assign last = (k == KW'(WORDS - 1));

    kogge_stone_4bit #(.bw(BW)) u_add (
        .a    (a_q[k]),
        .b    (b_q[k]),
        .cin  (carry),
        .s    (add_s),
        .cout (add_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake outputs; accept only from IDLE
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, per-chunk sum write and carry chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            sum_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    a_q   <= bus.A;
                    b_q   <= bus.B;
                    carry <= bus.cin;
                    k     <= '0;
                end
                RUN: begin
                    sum_q[k] <= add_s;
                    carry    <= add_co;
                    if (last) cout_q <= add_co;
                    else      k      <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef SIGNED_OVF_EN
    logic ovf_q;

    // Signed overflow judged on the top chunk as RUN finishes
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (state == RUN && last)
            ovf_q <= (a_q[WORDS-1][BW-1] == b_q[WORDS-1][BW-1]) &&
                     (add_s[BW-1] != a_q[WORDS-1][BW-1]);
    end

    assign bus.ovf = ovf_q;
`endif
endmodule
